// File: rtl/tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_pkg : shared constants and types for the TX bit serializer slice        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package tx_pkg;

  localparam int         TX_DATA_W_DFLT = 8;
  localparam logic [6:0] TX_SCR_SEED    = 7'h7F;
  localparam int         TX_SCR_TAP_A   = 6;
  localparam int         TX_SCR_TAP_B   = 3;

  typedef logic [6:0] scr_state_t;

endpackage : tx_pkg
`default_nettype wire

// File: rtl/tx_scrambler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_scrambler : additive x^7+x^4+1 scrambler, advances only when enabled    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tx_scrambler
  import tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv_i,
  input  logic raw_i,
  output logic scr_o
);

  scr_state_t state_q;
  scr_state_t state_d;
  logic       w_fb;

  assign w_fb  = state_q[TX_SCR_TAP_A] ^ state_q[TX_SCR_TAP_B];
  assign scr_o = raw_i ^ w_fb;

  always_comb begin
    state_d = state_q;
    if (adv_i) begin
      state_d = {state_q[5:0], w_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_SCR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule : tx_scrambler
`default_nettype wire

// File: rtl/tx_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_bit_serializer : word-to-bit serializer feeding the BPSK mapper         |
// | Optional scrambler on emitted bits when TX_SCRAMBLE_EN is defined.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tx_bit_serializer
  import tx_pkg::*;
#(
  parameter int DATA_W    = TX_DATA_W_DFLT,
  parameter int SYM_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam int               DIV_W    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
  logic [DATA_W-1:0] hold_q,      hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q,     shift_d;
  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic              bit_out_q,   bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              underrun_q,  underrun_d;

  logic w_tick;
  logic w_emit;
  logic w_xfer;
  logic w_accept;
  logic w_raw_bit;
  logic w_tx_bit;

  assign w_tick    = (div_cnt_q == DIV_LAST);
  assign w_emit    = w_tick && (shift_cnt_q != '0);
  // Reload on the same tick that drains the last bit keeps back-to-back words gapless.
  assign w_xfer    = hold_full_q &&
                     ((shift_cnt_q == '0) || (w_tick && (shift_cnt_q == CNT_W'(1))));
  assign w_accept  = s_valid && !hold_full_q;
  assign w_raw_bit = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];

`ifdef TX_SCRAMBLE_EN
  tx_scrambler u_scrambler (
    .clk   (clk),
    .rst   (rst),
    .adv_i (w_emit),
    .raw_i (w_raw_bit),
    .scr_o (w_tx_bit)
  );
`else
  assign w_tx_bit = w_raw_bit;
`endif

  always_comb begin
    div_cnt_d   = w_tick ? '0 : div_cnt_q + DIV_W'(1);
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    shift_cnt_d = shift_cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    underrun_d  = w_tick && (shift_cnt_q == '0);

    if (w_accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    if (w_emit) begin
      bit_out_d   = w_tx_bit;
      bit_valid_d = 1'b1;
      shift_d     = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};
      shift_cnt_d = shift_cnt_q - CNT_W'(1);
    end

    if (w_xfer) begin
      shift_d     = hold_q;
      shift_cnt_d = CNT_FULL;
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      shift_cnt_q <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      hold_full_q <= hold_full_d;
      shift_cnt_q <= shift_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  // Data registers carry no reset; their contents are qualified by the counters.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

  assign s_ready   = !hold_full_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign underrun  = underrun_q;
  assign busy      = (shift_cnt_q != '0) || hold_full_q;

endmodule : tx_bit_serializer
`default_nettype wire

// File: tb/tb_tx_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tx_bit_serializer : self-checking bench, two DUT configurations         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_tx_bit_serializer;

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] valid_v;
  logic [1:0] ready_v;
  logic [1:0] bo_v;
  logic [1:0] bv_v;
  logic [1:0] ur_v;
  logic [1:0] busy_v;
  logic [7:0] data_v [2];

  int         checks = 0;
  int         errors = 0;
  int         div_of [2];
  bit         msb_of [2];
  int         scr_m  [2];
  logic [7:0] wq[$];
  bit         exp_q[$];
  logic [7:0] pat;

  always #5 clk = ~clk;

  tx_bit_serializer #(.DATA_W(8), .SYM_DIV(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst_v[0]), .s_data(data_v[0]), .s_valid(valid_v[0]),
    .s_ready(ready_v[0]), .bit_out(bo_v[0]), .bit_valid(bv_v[0]),
    .underrun(ur_v[0]), .busy(busy_v[0])
  );

  tx_bit_serializer #(.DATA_W(8), .SYM_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst_v[1]), .s_data(data_v[1]), .s_valid(valid_v[1]),
    .s_ready(ready_v[1]), .bit_out(bo_v[1]), .bit_valid(bv_v[1]),
    .underrun(ur_v[1]), .busy(busy_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: word bits in transmit order, optionally scrambled by a 7-bit LFSR.
  task automatic load(input int d, input logic [7:0] w);
    wq.push_back(w);
    for (int i = 0; i < 8; i++) begin
      int b;
      b = msb_of[d] ? ((int'(w) >> (7 - i)) & 1) : ((int'(w) >> i) & 1);
`ifdef TX_SCRAMBLE_EN
      begin
        int fb;
        fb = ((scr_m[d] >> 6) ^ (scr_m[d] >> 3)) & 1;
        b = b ^ fb;
        scr_m[d] = ((scr_m[d] << 1) | fb) & 'h7F;
      end
`endif
      exp_q.push_back(b[0]);
    end
  endtask

  task automatic drive(input int d, input bit chk2);
    for (int i = 0; i < wq.size(); i++) begin
      int g;
      @(negedge clk);
      data_v[d]  = wq[i];
      valid_v[d] = 1'b1;
      g = 0;
      while (ready_v[d] !== 1'b1 && g < 400) begin
        @(negedge clk);
        g++;
      end
      if (g >= 400) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      if (chk2 && i == 1) begin
        @(negedge clk);
        chk("ready_after_second_accept", ready_v[d], 0);
      end
    end
    @(negedge clk);
    valid_v[d] = 1'b0;
  endtask

  task automatic collect(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      bit seen_ur;
      bit e;
      w = 0;
      seen_ur = 1'b0;
      do begin
        @(negedge clk);
        w++;
        if (ur_v[d] === 1'b1) seen_ur = 1'b1;
      end while (bv_v[d] !== 1'b1 && w < 200);
      chk("bit_valid_seen", bv_v[d], 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      chk($sformatf("bit_out[%0d]", k), bo_v[d], e);
      if (k > 0) begin
        chk("bit_spacing", w, div_of[d]);
        chk("no_underrun_in_stream", seen_ur, 0);
      end
    end
  endtask

  task automatic idle(input int d, input bit lastb, input int pulses);
    for (int p = 0; p < pulses; p++) begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (ur_v[d] !== 1'b1 && w < 200);
      chk("underrun_period", w, div_of[d]);
      chk("idle_bit_valid", bv_v[d], 0);
      chk("idle_bit_hold", bo_v[d], lastb);
    end
    chk("idle_busy", busy_v[d], 0);
    chk("idle_ready", ready_v[d], 1);
  endtask

  task automatic run_stream(input int d, input bit chk2);
    int n;
    bit lastb;
    n = exp_q.size();
    lastb = exp_q[n-1];
    fork
      drive(d, chk2);
      collect(d, n);
    join
    idle(d, lastb, 2);
    wq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    div_of[0] = 4; msb_of[0] = 1'b1;
    div_of[1] = 1; msb_of[1] = 1'b0;
    scr_m[0]  = 'h7F;
    scr_m[1]  = 'h7F;

    // Reset with s_valid asserted: nothing may be captured.
    rst_v     = 2'b11;
    valid_v   = 2'b11;
    data_v[0] = 8'hFF;
    data_v[1] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_bit_out", bo_v[d], 0);
      chk("rst_bit_valid", bv_v[d], 0);
      chk("rst_underrun", ur_v[d], 0);
      chk("rst_busy", busy_v[d], 0);
      chk("rst_ready", ready_v[d], 1);
    end
    rst_v   = 2'b00;
    valid_v = 2'b00;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bv_v != 2'b00 || busy_v != 2'b00) cnt++;
    end
    chk("post_rst_idle", cnt, 0);

    // Single word, MSB first, SYM_DIV=4.
    load(0, 8'hA5);
    run_stream(0, 1'b0);

    // Back-to-back words with valid held high, followed by random words.
    load(0, 8'h0F);
    load(0, 8'hF0);
    for (int i = 0; i < 4; i++) load(0, 8'($urandom));
    run_stream(0, 1'b1);

    // LSB first, SYM_DIV=1.
    load(1, 8'h01);
    for (int i = 0; i < 3; i++) load(1, 8'($urandom));
    run_stream(1, 1'b1);

    // Reset mid-word after three bits of 0xFF.
    load(0, 8'hFF);
    fork
      drive(0, 1'b0);
      collect(0, 3);
    join
    rst_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("midrst_bit_out", bo_v[0], 0);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_ready", ready_v[0], 1);
    exp_q.delete();
    wq.delete();
    scr_m[0] = 'h7F;
    cnt = 0;
    repeat (48) begin
      @(negedge clk);
      if (bv_v[0] === 1'b1) cnt++;
    end
    chk("midrst_no_more_bits", cnt, 0);

    // Two zero words straight after reset; scrambled build shows the LFSR sequence.
    load(0, 8'h00);
    load(0, 8'h00);
`ifdef TX_SCRAMBLE_EN
    pat = 8'b0000_1110;
    for (int i = 0; i < 8; i++) exp_q[i] = pat[7-i];
`endif
    run_stream(0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tx_bit_serializer
`default_nettype wire

// File: doc/tx_bit_serializer.md
Name: tx_bit_serializer

Overview:
- Upstream feeder for the 2-point QAM (BPSK) mapper in the baseband TX chain.
- Accepts parallel data words over a valid/ready handshake and emits one bit per symbol period to the mapper's single-bit input.
- Contains an internal symbol-rate divider, a one-word holding buffer and a shift register, so a new word can be accepted while the current word is shifting out. Back-to-back words produce a gapless bit stream.

Parameters:
- DATA_W, 8: input word width; legal range 2..32.
- SYM_DIV, 4: clk cycles per output bit; legal range 1..256.
- MSB_FIRST, 1: 1 = bit DATA_W-1 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  input word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  buffer can accept; combinational equal to !hold_full.
- bit_out  out  1  current bit to mapper; held constant for the whole symbol period.
- bit_valid  out  1  one-cycle pulse when bit_out takes a new bit.
- underrun  out  1  one-cycle pulse at a symbol tick with no bit available.
- busy  out  1  high while shift_cnt > 0 or hold_full.

Behaviour:
- Reset (rst=1 at an edge): div_cnt=0, hold_full=0, shift_cnt=0, bit_out=0, bit_valid=0, underrun=0. The shift register and the holding register contents are don't-care. A reset mid-word discards all pending bits. The mapper then sees bit 0, i.e. the +1 symbol.
- Divider:
  - div_cnt counts 0..SYM_DIV-1 and wraps to 0; it is free-running.
  - tick = (div_cnt == SYM_DIV-1). With SYM_DIV=1, tick is asserted every cycle.
- Accept: when s_valid && s_ready, hold <= s_data and hold_full <= 1.
- Transfer:
  - Condition: a cycle where hold_full && (shift_cnt == 0 || (tick && shift_cnt == 1)).
  - Action: shift <= hold, shift_cnt <= DATA_W (shift_cnt <= DATA_W after the final bit is emitted in the tick case), hold_full <= 0.
  - Transfer and accept never coincide, because s_ready = !hold_full.
- Emit, on tick with shift_cnt > 0:
  - bit_out <= next bit (MSB or LSB per MSB_FIRST).
  - shift shifts by one; shift_cnt decrements.
  - bit_valid <= 1 for one cycle.
- On tick with shift_cnt == 0: underrun <= 1 for one cycle; bit_valid=0; bit_out keeps its last value.
- Latency: the first bit appears at the first tick at least 2 cycles after the accept edge (accept edge, then transfer edge, then tick).
- Throughput: when hold is refilled within DATA_W*SYM_DIV-2 cycles of a transfer, consecutive words emit with no underrun.
- Width rule: shift_cnt is $clog2(DATA_W+1) bits; div_cnt is $clog2(SYM_DIV) bits, minimum 1.
- s_data is ignored when s_ready=0; no back-pressure error is flagged.

Optional Feature:
- Macro: TX_SCRAMBLE_EN.
- Defined:
  - An additive scrambler x^7+x^4+1 is applied to each emitted bit: bit_out = raw ^ (s[6]^s[3]), then s <= {s[5:0], s[6]^s[3]}.
  - The state advances only on emitted bits.
  - Seed 7'h7F is loaded on rst.
- Undefined: raw bits pass through and no LFSR logic is present.

Decomposition:
- Shared package tx_pkg:
  - Constants TX_DATA_W_DFLT=8, TX_SCR_SEED=7'h7F, TX_SCR_TAP_A=6, TX_SCR_TAP_B=3.
  - Typedef scr_state_t (logic [6:0]).
- Sub-module tx_scrambler (LFSR plus XOR, with an advance enable), instantiated only under TX_SCRAMBLE_EN. The divider and buffer logic stay inline.

Test Plan:
1. Reset: rst=1 for 3 cycles with s_valid=1 -> bit_out=0, bit_valid=0, underrun=0, busy=0, s_ready=1; no word is accepted.
2. Single word 0xA5, SYM_DIV=4, MSB_FIRST=1 -> bits 1,0,1,0,0,1,0,1 with bit_valid exactly 4 cycles apart, then underrun pulses every 4 cycles.
3. Back-to-back 0x0F then 0xF0 with s_valid held high:
   - s_ready drops after the second accept.
   - 16 contiguous bits 0000111111110000 are emitted with no underrun between them.
4. MSB_FIRST=0, word 0x01 -> output 1,0,0,0,0,0,0,0; SYM_DIV=1 gives bit_valid on 8 consecutive cycles.
5. rst pulsed for 1 cycle after 3 bits of 0xFF -> the next cycle shows bit_out=0, busy=0, s_ready=1; no remaining bits appear afterwards.
6. TX_SCRAMBLE_EN defined, two 0x00 words, MSB_FIRST=1 -> the first 8 emitted bits are 0,0,0,0,1,1,1,0; the full 16 bits match a bench LFSR model.
